// File: rtl/gpu_pkg.sv
// gpu_pkg: shared widths, command entry layout and issue FSM states for the GPU command queue
package gpu_pkg;

  function automatic int ww(input int fb_width);
    return $clog2(fb_width) + 3;
  endfunction

  function automatic int hw(input int fb_height);
    return $clog2(fb_height) + 3;
  endfunction

  localparam int ENT_WW = ww(400);
  localparam int ENT_HW = hw(240);

  typedef struct packed {
    logic              is_clear;
    logic [31:0]       address;
    logic [15:0]       address_x;
    logic [15:0]       address_y;
    logic [15:0]       image_width;
    logic [ENT_WW-1:0] width;
    logic [ENT_HW-1:0] height;
    logic [ENT_WW-1:0] x;
    logic [ENT_HW-1:0] y;
    logic [15:0]       clear_color;
  } cmd_entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_WAIT} issue_state_t;

endpackage

// File: rtl/gpu_cmd_fifo.sv
// gpu_cmd_fifo: registered synchronous FIFO with flush, full/empty and occupancy count
module gpu_cmd_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_q, rd_q;

  assign count = wr_q - rd_q;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout  = mem[rd_q[AW-1:0]];

  // pointers carry one extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
    end

  // storage needs no reset; only the pointers define validity
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_q[AW-1:0]] <= din;

endmodule

// File: rtl/gpu_cmd_queue.sv
// gpu_cmd_queue: buffers draw/clear commands and issues them to the GPU with edge strobes; GPU_CMDQ_STATS_EN adds issue counters
module gpu_cmd_queue
  import gpu_pkg::*;
#(
  parameter int FB_WIDTH = 400,
  parameter int FB_HEIGHT = 240,
  parameter int DEPTH = 8,
  localparam int WW = ww(FB_WIDTH),
  localparam int HW = hw(FB_HEIGHT),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_clear,
  input  logic [31:0]   cmd_address,
  input  logic [15:0]   cmd_address_x,
  input  logic [15:0]   cmd_address_y,
  input  logic [15:0]   cmd_image_width,
  input  logic [WW-1:0] cmd_width,
  input  logic [HW-1:0] cmd_height,
  input  logic [WW-1:0] cmd_x,
  input  logic [HW-1:0] cmd_y,
  input  logic [15:0]   cmd_clear_color,
  input  logic          cmd_flush,
  output logic [31:0]   ctrl_address,
  output logic [15:0]   ctrl_address_x,
  output logic [15:0]   ctrl_address_y,
  output logic [15:0]   ctrl_image_width,
  output logic [WW-1:0] ctrl_width,
  output logic [HW-1:0] ctrl_height,
  output logic [WW-1:0] ctrl_x,
  output logic [HW-1:0] ctrl_y,
  output logic [15:0]   ctrl_clear_color,
  output logic          ctrl_draw,
  output logic          ctrl_clear,
  input  logic          ctrl_busy,
  output logic [CW-1:0] queue_count,
  output logic          idle,
  output logic [31:0]   stat_draws,
  output logic [31:0]   stat_clears
);

  cmd_entry_t   push_entry, head;
  logic         full, empty, pop, clear_q;
  issue_state_t state_q, state_d;

  assign cmd_ready  = !full && !cmd_flush && !reset;
  assign pop        = state_q == ST_IDLE && !empty && !ctrl_busy && !cmd_flush;
  assign ctrl_draw  = state_q == ST_STROBE && !clear_q;
  assign ctrl_clear = state_q == ST_STROBE && clear_q;
  assign idle       = empty && state_q == ST_IDLE && !ctrl_busy;

  assign push_entry = '{is_clear: cmd_clear, address: cmd_address, address_x: cmd_address_x,
                        address_y: cmd_address_y, image_width: cmd_image_width, width: cmd_width,
                        height: cmd_height, x: cmd_x, y: cmd_y, clear_color: cmd_clear_color};

  gpu_cmd_fifo #(.W($bits(cmd_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid && cmd_ready),
    .pop   (pop),
    .flush (cmd_flush),
    .din   (push_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (queue_count)
  );

  // issue sequencing: a low SETUP cycle always precedes the one-cycle strobe
  always_comb
    state_d = (state_q == ST_IDLE)   ? (pop ? ST_SETUP : ST_IDLE) :
              (state_q == ST_SETUP)  ? ST_STROBE :
              (state_q == ST_STROBE) ? ST_WAIT :
              (ctrl_busy ? ST_WAIT : ST_IDLE);

  // state and GPU field registers; fields load only when the head is popped
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q          <= ST_IDLE;
      clear_q          <= 1'b0;
      ctrl_address     <= '0;
      ctrl_address_x   <= '0;
      ctrl_address_y   <= '0;
      ctrl_image_width <= '0;
      ctrl_width       <= '0;
      ctrl_height      <= '0;
      ctrl_x           <= '0;
      ctrl_y           <= '0;
      ctrl_clear_color <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        clear_q          <= head.is_clear;
        ctrl_address     <= head.address;
        ctrl_address_x   <= head.address_x;
        ctrl_address_y   <= head.address_y;
        ctrl_image_width <= head.image_width;
        ctrl_width       <= head.width;
        ctrl_height      <= head.height;
        ctrl_x           <= head.x;
        ctrl_y           <= head.y;
        ctrl_clear_color <= head.clear_color;
      end
    end

`ifdef GPU_CMDQ_STATS_EN
  // free-running issue counters, cleared only by reset
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stat_draws  <= '0;
      stat_clears <= '0;
    end else begin
      if (ctrl_draw) stat_draws <= stat_draws + 1'b1;
      if (ctrl_clear) stat_clears <= stat_clears + 1'b1;
    end
`else
  assign stat_draws  = '0;
  assign stat_clears = '0;
`endif

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// tb_gpu_cmd_queue: scoreboard bench for gpu_cmd_queue with a GPU busy model
module tb_gpu_cmd_queue;
  import gpu_pkg::*;

  logic clk = 0;
  logic reset = 1;
  logic cmd_valid = 0, cmd_flush = 0;
  cmd_entry_t drv = '0;
  logic cmd_ready, ctrl_draw, ctrl_clear, ctrl_busy, idle;
  logic [31:0] ctrl_address, stat_draws, stat_clears;
  logic [15:0] ctrl_address_x, ctrl_address_y, ctrl_image_width, ctrl_clear_color;
  logic [ENT_WW-1:0] ctrl_width, ctrl_x;
  logic [ENT_HW-1:0] ctrl_height, ctrl_y;
  logic [3:0] queue_count;

  int tests_run = 0, tests_failed = 0;
  int cyc = 0, strobes = 0, last_cyc = -1000, last_len = 0;
  int busy_len = 0, hold = 0;
  bit force_busy = 0;
  cmd_entry_t sb[$];
  cmd_entry_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gpu_cmd_queue dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_clear(drv.is_clear), .cmd_address(drv.address), .cmd_address_x(drv.address_x),
    .cmd_address_y(drv.address_y), .cmd_image_width(drv.image_width), .cmd_width(drv.width),
    .cmd_height(drv.height), .cmd_x(drv.x), .cmd_y(drv.y), .cmd_clear_color(drv.clear_color),
    .cmd_flush(cmd_flush), .ctrl_address(ctrl_address), .ctrl_address_x(ctrl_address_x),
    .ctrl_address_y(ctrl_address_y), .ctrl_image_width(ctrl_image_width), .ctrl_width(ctrl_width),
    .ctrl_height(ctrl_height), .ctrl_x(ctrl_x), .ctrl_y(ctrl_y), .ctrl_clear_color(ctrl_clear_color),
    .ctrl_draw(ctrl_draw), .ctrl_clear(ctrl_clear), .ctrl_busy(ctrl_busy),
    .queue_count(queue_count), .idle(idle), .stat_draws(stat_draws), .stat_clears(stat_clears)
  );

  // GPU model: busy combinationally with the strobe, then for busy_len more cycles
  assign ctrl_busy = ctrl_draw | ctrl_clear | (hold != 0) | force_busy;
  always @(posedge clk or posedge reset)
    if (reset) hold <= 0;
    else if (ctrl_draw || ctrl_clear) hold <= busy_len;
    else if (hold != 0) hold <= hold - 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // every strobe must match the oldest accepted command and respect issue spacing
  always @(negedge clk)
    if (!reset && (ctrl_draw || ctrl_clear)) begin
      strobes++;
      check("one_hot", 64'(ctrl_draw & ctrl_clear), 0);
      check("gap", 64'(cyc - last_cyc >= last_len + 4), 1);
      last_cyc = cyc;
      last_len = busy_len;
      if (sb.size() == 0) check("unexpected_strobe", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check("type", 64'(ctrl_clear), 64'(mon_e.is_clear));
        check("address", 64'(ctrl_address), 64'(mon_e.address));
        check("src", {ctrl_address_x, ctrl_address_y, ctrl_image_width},
              {mon_e.address_x, mon_e.address_y, mon_e.image_width});
        check("geom", 64'({ctrl_width, ctrl_height, ctrl_x, ctrl_y}),
              64'({mon_e.width, mon_e.height, mon_e.x, mon_e.y}));
        check("color", 64'(ctrl_clear_color), 64'(mon_e.clear_color));
      end
    end

  function automatic cmd_entry_t rand_entry(input bit is_clear);
    cmd_entry_t e;
    e.is_clear    = is_clear;
    e.address     = $urandom;
    e.address_x   = 16'($urandom);
    e.address_y   = 16'($urandom);
    e.image_width = 16'($urandom);
    e.width       = ENT_WW'($urandom);
    e.height      = ENT_HW'($urandom);
    e.x           = ENT_WW'($urandom);
    e.y           = ENT_HW'($urandom);
    e.clear_color = 16'($urandom);
    return e;
  endfunction

  task automatic push(input cmd_entry_t e, output bit acc);
    @(negedge clk);
    drv = e;
    cmd_valid = 1;
    #1 acc = cmd_ready;
    if (acc) sb.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && !(sb.size() == 0 && idle); i++) begin
      @(negedge clk);
      #1;
    end
    check("drain", 64'(sb.size() == 0 && idle), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int n, s0;
    cmd_entry_t e;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(cmd_ready), 0);
    check("rst_draw", 64'(ctrl_draw | ctrl_clear), 0);
    check("rst_count", 64'(queue_count), 0);
    check("rst_address", 64'(ctrl_address), 0);
    @(negedge clk) reset = 0;
    #1;
    check("post_rst_ready", 64'(cmd_ready), 1);
    check("post_rst_idle", 64'(idle), 1);
    check("post_rst_stats", {stat_draws, stat_clears}, 0);

    e = rand_entry(0);
    e.address = 32'h1000;
    e.width = 16;
    e.height = 8;
    push(e, acc);
    check("single_acc", 64'(acc), 1);
    @(negedge clk);
    check("k1_draw", 64'(ctrl_draw), 0);
    @(negedge clk);
    check("setup_draw", 64'(ctrl_draw), 0);
    check("setup_addr", 64'(ctrl_address), 32'h1000);
    @(negedge clk);
    check("k3_draw", 64'(ctrl_draw), 1);
    check("k3_clear", 64'(ctrl_clear), 0);
    wait_drain(50);

    force_busy = 1;
    n = 0;
    for (int i = 0; i < 9; i++) begin
      push(rand_entry(i[0]), acc);
      n += int'(acc);
    end
    check("fill_accepted", 64'(n), 8);
    check("fill_count", 64'(queue_count), 8);
    check("fill_ready", 64'(cmd_ready), 0);
    s0 = strobes;
    force_busy = 0;
    wait_drain(200);
    check("fill_strobes", 64'(strobes - s0), 8);

    busy_len = 50;
    s0 = strobes;
    for (int i = 0; i < 3; i++) push(rand_entry(i == 1), acc);
    wait_drain(400);
    check("busy_strobes", 64'(strobes - s0), 3);

    busy_len = 20;
    s0 = strobes;
    for (int i = 0; i < 6; i++) push(rand_entry(i[0]), acc);
    check("flush_pre_strobes", 64'(strobes - s0), 1);
    check("flush_pre_count", 64'(queue_count), 5);
    @(negedge clk);
    drv = rand_entry(0);
    cmd_flush = 1;
    cmd_valid = 1;
    #1 check("flush_ready", 64'(cmd_ready), 0);
    @(posedge clk);
    #1 cmd_flush = 0;
    cmd_valid = 0;
    check("flush_count", 64'(queue_count), 0);
    sb.delete();
    wait_drain(100);
    repeat (30) @(negedge clk);
    check("flush_no_more", 64'(strobes - s0), 1);

    busy_len = 0;
    for (int i = 0; i < 3; i++) push(rand_entry(0), acc);
    for (int i = 0; i < 20 && !ctrl_draw; i++) begin
      @(negedge clk);
      #1;
    end
    check("ar_saw_strobe", 64'(ctrl_draw), 1);
    reset = 1;
    #1;
    check("ar_draw", 64'(ctrl_draw), 0);
    check("ar_count", 64'(queue_count), 0);
    check("ar_ready", 64'(cmd_ready), 0);
    sb.delete();
    @(posedge clk);
    @(negedge clk) reset = 0;
    #1;
    check("ar_idle", 64'(idle), 1);
    check("ar_ready_after", 64'(cmd_ready), 1);
    check("ar_stats", {stat_draws, stat_clears}, 0);

    for (int i = 0; i < 5; i++) push(rand_entry(i >= 3), acc);
    wait_drain(200);
`ifdef GPU_CMDQ_STATS_EN
    check("stat_draws", 64'(stat_draws), 3);
    check("stat_clears", 64'(stat_clears), 2);
`else
    check("stat_draws", 64'(stat_draws), 0);
    check("stat_clears", 64'(stat_clears), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
